// File: rtl/fifo_frame_writer_pkg.sv
// Shared definitions for the frame writer: FSM state encoding, header magic and default length.
// Header words are only emitted when FIFO_FRAME_HEADER_EN is defined.
package fifo_frame_writer_pkg;

    localparam int unsigned DEFAULT_FRAME_LEN = 128;
    localparam logic [15:0] HDR_MAGIC         = 16'hFACE;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_HEADER_ENC = 3'd1;
    localparam logic [2:0] ST_DATA_ENC   = 3'd2;
    localparam logic [2:0] ST_PAD_ENC    = 3'd3;
    localparam logic [2:0] ST_DROP_ENC   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_HEADER = ST_HEADER_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PAD    = ST_PAD_ENC,
        ST_DROP   = ST_DROP_ENC
    } state_t;

    function automatic logic [31:0] header_word(input logic [7:0] idx, input logic [7:0] last_idx);
        return {HDR_MAGIC, idx, last_idx};
    endfunction

endpackage

// File: rtl/fifo_frame_writer.sv
// Packs an AXI-stream into fixed-length frames for a host-bound FIFO: pads short frames,
// drops the tail of long ones. Define FIFO_FRAME_HEADER_EN to prefix each frame with a header.
module fifo_frame_writer
    import fifo_frame_writer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              bus_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              fifo_wren,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] fifo_din,
    output logic              frame_done,
    output logic [7:0]        frame_idx,
    output logic              len_error
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     state_q;
    logic [7:0] wcnt_q;
    logic [7:0] frame_idx_q;
    logic       len_error_q;

    logic tready_raw;
    logic wren_raw;
    logic done_raw;
    logic at_last;

    assign at_last = (wcnt_q == LAST_IDX);

    // Handshake and write data are combinational so a DATA word reaches the FIFO with zero latency.
    always_comb begin
        tready_raw = 1'b0;
        wren_raw   = 1'b0;
        done_raw   = 1'b0;
        fifo_din   = '0;
        unique case (state_q)
`ifdef FIFO_FRAME_HEADER_EN
            ST_HEADER: begin
                wren_raw = !fifo_full;
                fifo_din = DATA_W'(header_word(frame_idx_q, LAST_IDX));
            end
`endif
            ST_DATA: begin
                tready_raw = !fifo_full;
                wren_raw   = s_axis_tvalid && !fifo_full;
                done_raw   = wren_raw && at_last;
                fifo_din   = s_axis_tdata;
            end
            ST_PAD: begin
                wren_raw = !fifo_full;
                done_raw = wren_raw && at_last;
            end
            ST_DROP: begin
                tready_raw = 1'b1;
            end
            default: begin
                tready_raw = 1'b0;
            end
        endcase
    end

    // Reset gates the handshake outputs immediately, abandoning any partial frame.
    assign s_axis_tready = tready_raw && !rst;
    assign fifo_wren     = wren_raw && !rst;
    assign frame_done    = done_raw && !rst;
    assign frame_idx     = frame_idx_q;
    assign len_error     = len_error_q;

    always_ff @(posedge bus_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= 8'd0;
            frame_idx_q <= 8'd0;
            len_error_q <= 1'b0;
        end else begin
            if (done_raw) begin
                frame_idx_q <= frame_idx_q + 8'd1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    wcnt_q <= 8'd0;
                    if (s_axis_tvalid) begin
`ifdef FIFO_FRAME_HEADER_EN
                        state_q <= ST_HEADER;
`else
                        state_q <= ST_DATA;
`endif
                    end
                end
`ifdef FIFO_FRAME_HEADER_EN
                ST_HEADER: begin
                    if (!fifo_full) begin
                        state_q <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (wren_raw) begin
                        if (at_last) begin
                            if (s_axis_tlast) begin
                                state_q <= ST_IDLE;
                                wcnt_q  <= 8'd0;
                            end else begin
                                state_q     <= ST_DROP;
                                len_error_q <= 1'b1;
                            end
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                            if (s_axis_tlast) begin
                                state_q     <= ST_PAD;
                                len_error_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (wren_raw) begin
                        if (at_last) begin
                            state_q <= ST_IDLE;
                            wcnt_q  <= 8'd0;
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state_q <= ST_IDLE;
                        wcnt_q  <= 8'd0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wcnt_q  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Bench for fifo_frame_writer: cycle table on a 4-word instance, frame scenarios on a 128-word one.
// Honours FIFO_FRAME_HEADER_EN the same way as the design.
module tb_fifo_frame_writer;

`ifdef FIFO_FRAME_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // Small instance (FRAME_LEN=4) for the cycle table.
    logic        s_rst, s_tvalid, s_tlast, s_tready, s_wren, s_full, s_done, s_lerr;
    logic [31:0] s_tdata, s_din;
    logic [7:0]  s_idx;

    // Default-length instance for the frame scenarios.
    logic        b_rst, b_tvalid, b_tlast, b_tready, b_wren, b_full, b_done, b_lerr;
    logic [31:0] b_tdata, b_din;
    logic [7:0]  b_idx;

    fifo_frame_writer #(.FRAME_LEN(4), .DATA_W(32)) u_small (
        .bus_clk(bus_clk), .rst(s_rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready), .fifo_wren(s_wren),
        .fifo_full(s_full), .fifo_din(s_din), .frame_done(s_done), .frame_idx(s_idx),
        .len_error(s_lerr)
    );

    fifo_frame_writer #(.FRAME_LEN(128), .DATA_W(32)) u_big (
        .bus_clk(bus_clk), .rst(b_rst), .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid),
        .s_axis_tlast(b_tlast), .s_axis_tready(b_tready), .fifo_wren(b_wren),
        .fifo_full(b_full), .fifo_din(b_din), .frame_done(b_done), .frame_idx(b_idx),
        .len_error(b_lerr)
    );

    typedef struct {
        logic        rst, tvalid, tlast;
        logic [31:0] tdata;
        logic        full;
        logic        e_tready, e_wren;
        logic [31:0] e_din;
        logic        e_done, e_lerr;
        logic [7:0]  e_idx;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          nwr = 0;
    int          ndone = 0;
    int          done_at = 0;
    int          nlerr = 0;
    int          wren_full_viol = 0;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge bus_clk) begin
        if (b_wren) begin
            got.push_back(b_din);
            nwr = nwr + 1;
        end
        if (b_done) begin
            ndone = ndone + 1;
            done_at = nwr;
        end
        if (b_lerr === 1'b1) nlerr = nlerr + 1;
        if (b_wren && b_full) wren_full_viol = wren_full_viol + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic add_v(input logic rst, input logic tv, input logic tl, input logic [31:0] td,
                         input logic full, input logic er, input logic ew, input logic [31:0] ed,
                         input logic edone, input logic elerr, input logic [7:0] eidx);
        vec_t v;
        v.rst = rst; v.tvalid = tv; v.tlast = tl; v.tdata = td; v.full = full;
        v.e_tready = er; v.e_wren = ew; v.e_din = ed; v.e_done = edone;
        v.e_lerr = elerr; v.e_idx = eidx;
        vecs.push_back(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge bus_clk);
            #1;
        end
    endtask

    // Presents n words; tlast on word last_at; holds fifo_full for 5 cycles at word stall_at.
    task automatic send_frame(input int n, input int last_at, input logic [31:0] base,
                              input int stall_at);
        logic acc;
        int   cyc;
        for (int i = 0; i < n; i++) begin
            b_tvalid = 1'b1;
            b_tdata  = base + 32'(i);
            b_tlast  = (i == last_at);
            if (i == stall_at) begin
                b_full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge bus_clk);
                    chk("stall tready", {31'd0, b_tready}, 32'd0);
                    chk("stall wren", {31'd0, b_wren}, 32'd0);
                    @(posedge bus_clk);
                    #1;
                end
                b_full = 1'b0;
            end
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 200) begin
                @(negedge bus_clk);
                acc = b_tready;
                @(posedge bus_clk);
                #1;
                cyc++;
            end
            if (!acc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept timeout: word %0d not accepted within %0d cycles", i, cyc);
                break;
            end
        end
        b_tvalid = 1'b0;
        b_tlast  = 1'b0;
    endtask

    task automatic build_exp(input logic [31:0] base, input int ndata, input int npad,
                             input logic [7:0] idx);
        exp_q.delete();
        if (HDR == 1) exp_q.push_back({16'hFACE, idx, 8'd127});
        for (int i = 0; i < ndata; i++) exp_q.push_back(base + 32'(i));
        for (int i = 0; i < npad; i++) exp_q.push_back(32'd0);
    endtask

    task automatic check_writes(input string name, input int base_wr);
        int bad;
        int first;
        bad = 0;
        first = -1;
        chk({name, " write count"}, 32'(nwr - base_wr), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && (base_wr + k) < got.size(); k++) begin
            if (got[base_wr + k] !== exp_q[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s contents: %0d words differ, first at %0d got %h expected %h",
                     name, bad, first, got[base_wr + first], exp_q[first]);
        end
    endtask

    initial begin
        int w0, d0, l0;

        s_rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_full = 1'b0;
        b_rst = 1'b1; b_tvalid = 1'b0; b_tlast = 1'b0; b_tdata = '0; b_full = 1'b0;
        idle(3);
        b_rst = 1'b0;

        // rst tv tl tdata full | tready wren din done lerr idx
        add_v(1, 1, 0, 32'hA0, 0,  0, 0, 0,      0, 0, 0);
        add_v(0, 1, 0, 32'hA0, 0,  0, 0, 0,      0, 0, 0);
`ifdef FIFO_FRAME_HEADER_EN
        add_v(0, 1, 0, 32'hA0, 0,  0, 1, 32'hFACE0003, 0, 0, 0);
`endif
        add_v(0, 1, 0, 32'hA0, 0,  1, 1, 32'hA0, 0, 0, 0);
        add_v(0, 1, 0, 32'hA1, 1,  0, 0, 0,      0, 0, 0);
        add_v(0, 1, 0, 32'hA1, 0,  1, 1, 32'hA1, 0, 0, 0);
        add_v(0, 0, 0, 32'h00, 0,  1, 0, 0,      0, 0, 0);
        add_v(0, 1, 0, 32'hA2, 0,  1, 1, 32'hA2, 0, 0, 0);
        add_v(0, 1, 1, 32'hA3, 0,  1, 1, 32'hA3, 1, 0, 0);
        add_v(0, 0, 0, 32'h00, 0,  0, 0, 0,      0, 0, 1);
        add_v(0, 1, 1, 32'hB0, 0,  0, 0, 0,      0, 0, 1);
`ifdef FIFO_FRAME_HEADER_EN
        add_v(0, 1, 1, 32'hB0, 0,  0, 1, 32'hFACE0103, 0, 0, 1);
`endif
        add_v(0, 1, 1, 32'hB0, 0,  1, 1, 32'hB0, 0, 0, 1);
        add_v(0, 0, 0, 32'h00, 0,  0, 1, 32'h0,  0, 1, 1);
        add_v(0, 0, 0, 32'h00, 1,  0, 0, 0,      0, 1, 1);
        add_v(0, 0, 0, 32'h00, 0,  0, 1, 32'h0,  0, 1, 1);
        add_v(0, 0, 0, 32'h00, 0,  0, 1, 32'h0,  1, 1, 1);
        add_v(0, 1, 0, 32'hC0, 0,  0, 0, 0,      0, 1, 2);
`ifdef FIFO_FRAME_HEADER_EN
        add_v(0, 1, 0, 32'hC0, 0,  0, 1, 32'hFACE0203, 0, 1, 2);
`endif
        add_v(0, 1, 0, 32'hC0, 0,  1, 1, 32'hC0, 0, 1, 2);
        add_v(0, 1, 0, 32'hC1, 0,  1, 1, 32'hC1, 0, 1, 2);
        add_v(0, 1, 0, 32'hC2, 0,  1, 1, 32'hC2, 0, 1, 2);
        add_v(0, 1, 0, 32'hC3, 0,  1, 1, 32'hC3, 1, 1, 2);
        add_v(0, 1, 0, 32'hC4, 0,  1, 0, 0,      0, 1, 3);
        add_v(0, 1, 1, 32'hC5, 0,  1, 0, 0,      0, 1, 3);
        add_v(0, 0, 0, 32'h00, 0,  0, 0, 0,      0, 1, 3);
        add_v(1, 1, 0, 32'hD0, 0,  0, 0, 0,      0, 1, 3);
        add_v(0, 0, 0, 32'h00, 0,  0, 0, 0,      0, 0, 0);
        add_v(0, 1, 0, 32'hD0, 0,  0, 0, 0,      0, 0, 0);
`ifdef FIFO_FRAME_HEADER_EN
        add_v(0, 1, 0, 32'hD0, 0,  0, 1, 32'hFACE0003, 0, 0, 0);
`endif
        add_v(0, 1, 0, 32'hD0, 0,  1, 1, 32'hD0, 0, 0, 0);
        add_v(1, 1, 0, 32'hD1, 0,  0, 0, 0,      0, 0, 0);
        add_v(0, 0, 0, 32'h00, 0,  0, 0, 0,      0, 0, 0);
        add_v(0, 1, 0, 32'hD1, 0,  0, 0, 0,      0, 0, 0);

        foreach (vecs[i]) begin
            s_rst = vecs[i].rst; s_tvalid = vecs[i].tvalid; s_tlast = vecs[i].tlast;
            s_tdata = vecs[i].tdata; s_full = vecs[i].full;
            @(negedge bus_clk);
            chk($sformatf("v%0d tready", i), {31'd0, s_tready}, {31'd0, vecs[i].e_tready});
            chk($sformatf("v%0d wren", i), {31'd0, s_wren}, {31'd0, vecs[i].e_wren});
            if (vecs[i].e_wren) chk($sformatf("v%0d din", i), s_din, vecs[i].e_din);
            chk($sformatf("v%0d done", i), {31'd0, s_done}, {31'd0, vecs[i].e_done});
            chk($sformatf("v%0d len_error", i), {31'd0, s_lerr}, {31'd0, vecs[i].e_lerr});
            chk($sformatf("v%0d frame_idx", i), {24'd0, s_idx}, {24'd0, vecs[i].e_idx});
            @(posedge bus_clk);
            #1;
        end
        s_tvalid = 1'b0;

        chk("big reset idx", {24'd0, b_idx}, 32'd0);
        chk("big reset len_error", {31'd0, b_lerr}, 32'd0);

        // Good frame.
        w0 = nwr; d0 = ndone;
        send_frame(128, 127, 32'h1000, -1);
        idle(2);
        build_exp(32'h1000, 128, 0, 8'd0);
        check_writes("good", w0);
        chk("good done count", 32'(ndone - d0), 32'd1);
        chk("good idx", {24'd0, b_idx}, 32'd1);
        chk("good len_error", {31'd0, b_lerr}, 32'd0);

        // Back-pressure at word 40.
        w0 = nwr;
        send_frame(128, 127, 32'h2000, 40);
        idle(2);
        build_exp(32'h2000, 128, 0, 8'd1);
        check_writes("stall", w0);
        chk("stall idx", {24'd0, b_idx}, 32'd2);

        // Short frame: 100 words then 28 pad words.
        w0 = nwr; d0 = ndone;
        send_frame(100, 99, 32'h3000, -1);
        idle(40);
        build_exp(32'h3000, 100, 28, 8'd2);
        check_writes("short", w0);
        chk("short done count", 32'(ndone - d0), 32'd1);
        chk("short done position", 32'(done_at - w0), 32'(128 + HDR));
        chk("short len_error", {31'd0, b_lerr}, 32'd1);
        chk("short idx", {24'd0, b_idx}, 32'd3);

        // Long frame: words 128-129 dropped.
        w0 = nwr; d0 = ndone;
        send_frame(130, 129, 32'h4000, -1);
        idle(3);
        build_exp(32'h4000, 128, 0, 8'd3);
        check_writes("long", w0);
        chk("long done count", 32'(ndone - d0), 32'd1);
        chk("long len_error", {31'd0, b_lerr}, 32'd1);
        chk("long idx", {24'd0, b_idx}, 32'd4);

        // Reset at word 60.
        w0 = nwr;
        send_frame(60, -1, 32'h5000, -1);
        b_tvalid = 1'b1; b_tdata = 32'h5000 + 32'd60; b_rst = 1'b1;
        @(negedge bus_clk);
        chk("rst tready", {31'd0, b_tready}, 32'd0);
        chk("rst wren", {31'd0, b_wren}, 32'd0);
        @(posedge bus_clk);
        #1;
        b_rst = 1'b0; b_tvalid = 1'b0;
        idle(10);
        build_exp(32'h5000, 60, 0, 8'd4);
        check_writes("rst partial", w0);
        chk("rst idx", {24'd0, b_idx}, 32'd0);
        chk("rst len_error", {31'd0, b_lerr}, 32'd0);
        w0 = nwr;
        send_frame(128, 127, 32'h6000, -1);
        idle(2);
        build_exp(32'h6000, 128, 0, 8'd0);
        check_writes("after rst", w0);
        chk("after rst idx", {24'd0, b_idx}, 32'd1);

        // 256 back-to-back good frames wrap frame_idx.
        b_rst = 1'b1;
        idle(1);
        b_rst = 1'b0;
        w0 = nwr; d0 = ndone; l0 = nlerr;
        for (int f = 0; f < 256; f++) begin
            send_frame(128, 127, 32'(f) << 16, -1);
            if (f == 254) chk("wrap idx 255", {24'd0, b_idx}, 32'd255);
        end
        idle(2);
        chk("wrap idx", {24'd0, b_idx}, 32'd0);
        chk("wrap writes", 32'(nwr - w0), 32'(256 * (128 + HDR)));
        chk("wrap done count", 32'(ndone - d0), 32'd256);
        chk("wrap len_error cycles", 32'(nlerr - l0), 32'd0);
        chk("wren while full", 32'(wren_full_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
